sif_pack_half_fp: RTL
=====================

Name: sif_pack_half_fp

Overview:
- Downstream stage of the half-precision FP multiplier.
- Consumes the multiplier's 16-bit product stream (P_vld/P_dat/P_rdy) and packs LANES consecutive products into one wide word for the write-back/SRAM path.
- A last flag closes a partial word early, zero-padded, with lane count reported.
- Full valid/ready backpressure on both sides. Holds up to LANES-1 products while the output is stalled.

Parameters:
- LANES, 4, products per packed output word (integer >= 2).
- CW, $clog2(LANES+1), width of the lane-count field (derived; do not override).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- P_vld  input  1  product valid from multiplier
- P_dat  input  16  half-precision product
- P_last  input  1  this product ends the current group; qualified by P_vld
- P_rdy  output  1  stage can accept a product
- Q_vld  output  1  packed word valid
- Q_dat  output  16*LANES  packed word; lane i at bits [16*i+15:16*i]
- Q_cnt  output  CW  number of valid lanes in Q_dat (1..LANES)
- Q_last  output  1  word closes a group (P_last seen in it)
- Q_rdy  input  1  downstream accepts packed word

Behaviour:
- Reset, sampled on the rising clk edge with rst_n=0:
  - Q_vld=0, Q_dat=0, Q_cnt=0, Q_last=0.
  - Lane counter cnt=0, assembly register=0, state=ASM.
  - P_rdy=0 while rst_n=0.
  - Reset mid-word discards any partial word and any unaccepted output word.
- Transfers: input beat occurs on P_vld&&P_rdy; output beat on Q_vld&&Q_rdy. Both are evaluated at the same edge.
- out_free = !Q_vld || Q_rdy.
- State ASM:
  - P_rdy = (cnt < LANES-1) || out_free.
  - A beat writes P_dat into lane cnt of the assembly register.
  - Non-closing beat (cnt < LANES-1 and !P_last): cnt increments.
  - Closing beat (cnt == LANES-1 or P_last) with out_free:
    - The assembly register plus the new lane loads the output register; lanes above cnt are forced to 0.
    - Q_cnt=cnt+1, Q_last=P_last, Q_vld=1 from the next cycle.
    - cnt=0 and the assembly register clears.
  - Closing beat with !out_free (only possible for P_last with cnt < LANES-1): the lane is stored and state goes to PEND.
- State PEND:
  - P_rdy=0.
  - When out_free, the held word loads the output register (Q_last=1, Q_cnt=stored count). cnt=0, state goes to ASM.
- Output register:
  - Q_dat/Q_cnt/Q_last are stable while Q_vld && !Q_rdy.
  - Q_vld falls after an output beat unless a new word loads at the same edge.
  - Output beat and new load at the same edge give back-to-back words with no bubble.
- Latency: the closing product is accepted at edge k and the word is visible with Q_vld=1 in the cycle after edge k (1 cycle).
- Sustained throughput: 1 product/cycle, 1 word per LANES cycles, when Q_rdy=1.
- P_dat is forwarded bit-exact; no FP interpretation. NaN/Inf/denormal patterns pass unchanged.
- P_last on the LANES-th lane: a normal full word with Q_last=1.
- P_last as the first lane: word with Q_cnt=1.
- P_dat/P_last are ignored when P_vld=0 or P_rdy=0.

Test Plan:
- LANES=4, Q_rdy=1, products 0x3C00,0x4000,0x4200,0x4400 on 4 consecutive cycles, P_last=0 -> one cycle after the 4th beat: Q_vld=1, Q_dat=0x4400_4200_4000_3C00, Q_cnt=4, Q_last=0. P_rdy stays 1 throughout.
- Q_rdy=1, 12 products back-to-back -> 3 words on cycles 5, 9, 13 after the first beat; every product stays in order; no P_rdy drop.
- Products 0x1111,0x2222 with P_last on 2nd, Q_rdy=1 -> Q_dat=0x0000_0000_2222_1111, Q_cnt=2, Q_last=1. The next word starts at lane 0.
- Full word pending with Q_rdy=0, then 3 more products -> all 3 accepted. P_rdy=0 when the 4th is offered. The first word is held stable. Q_rdy=1 for one cycle drains it and the 4th lands in the same edge.
- Q_rdy=0 with word pending, then products 0xAAAA (P_last) -> accepted, P_rdy=0 (PEND). After Q_rdy pulses, the next word is 0xAAAA with Q_cnt=1, Q_last=1.
- 2 lanes assembled, rst_n=0 for one cycle -> Q_vld=0, Q_dat=0. Subsequent 4 products form a clean word with no residue from the discarded lanes.

Source files
------------

// File: rtl/sif_pack_half_fp.sv
`default_nettype none
// ============================================================================
// Module   : sif_pack_half_fp
// Brief    : Packs LANES consecutive half-precision products into one wide word
//            with valid/ready on both sides; P_last closes a zero-padded word.
// Revision : 1.0 - initial release
// ============================================================================
module sif_pack_half_fp #(
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  P_vld,
    input  logic [15:0]           P_dat,
    input  logic                  P_last,
    output logic                  P_rdy,
    output logic                  Q_vld,
    output logic [16*LANES-1:0]   Q_dat,
    output logic [CW-1:0]         Q_cnt,
    output logic                  Q_last,
    input  logic                  Q_rdy
);

    localparam logic [0:0]    c_ASM  = 1'b0;
    localparam logic [0:0]    c_PEND = 1'b1;
    localparam logic [CW-1:0] c_LAST = CW'(LANES - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [16*LANES-1:0] r_asm;
    logic [16*LANES-1:0] r_q_dat;
    logic [CW-1:0]       r_q_cnt;
    logic                r_q_last;
    logic                r_q_vld;

    logic                w_out_free;
    logic                w_beat;
    logic                w_close;
    logic                w_load;
    logic [16*LANES-1:0] w_asm_new;
    logic [16*LANES-1:0] w_load_dat;
    logic [CW-1:0]       w_load_cnt;
    logic                w_load_last;

    assign w_out_free = !r_q_vld || Q_rdy;
    assign P_rdy      = rst_n && (r_state == c_ASM) && ((r_cnt < c_LAST) || w_out_free);
    assign w_beat     = P_vld && P_rdy;
    assign w_close    = w_beat && ((r_cnt == c_LAST) || P_last);

    // New lane inserted at r_cnt; lanes above it forced to zero for partial words.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_asm_new[16*i +: 16] = (r_cnt == CW'(i)) ? P_dat :
                                       (r_cnt >  CW'(i)) ? r_asm[16*i +: 16] : 16'h0000;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_dat  = w_asm_new;
        w_load_cnt  = r_cnt + 1'b1;
        w_load_last = P_last;
        case (r_state)
            c_ASM: begin
                if (w_close) begin
                    if (w_out_free) w_load = 1'b1;
                    else            w_state_nxt = c_PEND;
                end
            end
            default: begin
                // In PEND r_cnt already holds the lane count of the parked word.
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_dat  = r_asm;
                    w_load_cnt  = r_cnt;
                    w_load_last = 1'b1;
                    w_state_nxt = c_ASM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ASM;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_asm    <= '0;
            r_q_dat  <= '0;
            r_q_cnt  <= '0;
            r_q_last <= 1'b0;
            r_q_vld  <= 1'b0;
        end else begin
            if (w_load) begin
                r_q_dat  <= w_load_dat;
                r_q_cnt  <= w_load_cnt;
                r_q_last <= w_load_last;
                r_q_vld  <= 1'b1;
            end else if (r_q_vld && Q_rdy) begin
                r_q_vld  <= 1'b0;
            end
            if (w_load) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else if (w_beat) begin
                r_asm <= w_asm_new;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Q_vld  = r_q_vld;
    assign Q_dat  = r_q_dat;
    assign Q_cnt  = r_q_cnt;
    assign Q_last = r_q_last;

endmodule
`default_nettype wire
